// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter_param
//  Description : Parametrised synchronous up/down counter with configurable
//                modulus, wrap or saturate end behaviour, parallel load,
//                count enable and registered carry/borrow pulses for chaining.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             U,
  input  logic             D,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_zero
);

  // Largest reachable count; with MODULUS == 2**WIDTH this is all ones and
  // wrapping degenerates to natural binary overflow.
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam bit               SAT_MODE  = (SATURATE != 0);

  // Reject illegal parameter sets at elaboration so a bad instance never builds.
  if ((WIDTH < 1) || (MODULUS < 2) || (MODULUS > (1 << WIDTH)) ||
      (RESET_VALUE < 0) || (RESET_VALUE >= MODULUS)) begin : g_param_check
    $error("updown_counter_param: illegal WIDTH/MODULUS/RESET_VALUE combination");
  end

  logic [WIDTH-1:0] q_next;
  logic             carry_next;
  logic             borrow_next;
  logic             step_up;
  logic             step_down;
  logic [WIDTH-1:0] load_clamped;

  // A step happens only with enable and exactly one direction request.
  assign step_up      = en & U & ~D;
  assign step_down    = en & D & ~U;
  // Out-of-range load values are pulled back to the top of the range.
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Next-state selection: load beats counting; pulses default low every edge.
  always_comb begin
    q_next      = q;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (load) begin
      q_next = load_clamped;
    end else if (step_up) begin
      if (q == MAX_VAL) begin
        if (!SAT_MODE) begin
          q_next     = '0;
          carry_next = 1'b1;
        end
      end else begin
        q_next = q + ONE;
      end
    end else if (step_down) begin
      if (q == '0) begin
        if (!SAT_MODE) begin
          q_next      = MAX_VAL;
          borrow_next = 1'b1;
        end
      end else begin
        q_next = q - ONE;
      end
    end
  end

  // Counter and pulse registers; reset overrides everything including load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= RST_VAL;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      q      <= q_next;
      carry  <= carry_next;
      borrow <= borrow_next;
    end
  end

  // End-of-range flags follow q directly, no extra latency.
  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);

endmodule
`default_nettype wire
